// File: rtl/cpu_io_decoder.sv
// rtl/cpu_io_decoder.sv - Z80 I/O cycle decoder: synchronizes CPU strobes and
// produces per-channel hit, read/write strobes, address/data latches and wait requests.
module cpu_io_decoder #(
  parameter int                     PORTS       = 4,
  parameter int                     SYNC_STAGES = 2,
  parameter logic [PORTS*16-1:0]    PORT_ADDR   = '0,
  parameter logic [PORTS*16-1:0]    PORT_MASK   = '0,
  parameter int                     WAIT_CYCLES = 4
) (
  input  logic             clk28,
  input  logic             rst,
  input  logic [15:0]      a,
  input  logic [7:0]       d,
  input  logic             n_iorq,
  input  logic             n_m1,
  input  logic             n_rd,
  input  logic             n_wr,
  input  logic [PORTS-1:0] port_en,
  input  logic [PORTS-1:0] port_wait,
  output logic             ioreq,
  output logic [PORTS-1:0] hit,
  output logic [PORTS-1:0] rd_stb,
  output logic [PORTS-1:0] wr_stb,
  output logic [15:0]      addr_lat,
  output logic [7:0]       data_lat,
  output logic             n_wait
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACCESS, S_DONE} state_t;

  // Strobes travel as {n_wr, n_rd, n_m1, n_iorq}; reset to the inactive (high) level.
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic                        iorq_s, m1_s, rd_s, wr_s, cond;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ioreq_q, ioreq_d;
  logic             n_wait_q, n_wait_d;
  logic [PORTS-1:0] hit_q, hit_d;
  logic [PORTS-1:0] rd_q, rd_d;
  logic [PORTS-1:0] wr_q, wr_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [PORTS-1:0] win;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {n_wr, n_rd, n_m1, n_iorq}};
  end

  assign iorq_s = ~sync_q[SYNC_STAGES-1][0];
  assign m1_s   = ~sync_q[SYNC_STAGES-1][1];
  assign rd_s   = ~sync_q[SYNC_STAGES-1][2];
  assign wr_s   = ~sync_q[SYNC_STAGES-1][3];
  assign cond   = iorq_s & ~m1_s;

  // Descending scan so the lowest matching index is the last writer and wins.
  always_comb begin
    win = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (port_en[i] && (((a ^ PORT_ADDR[16*i +: 16]) & PORT_MASK[16*i +: 16]) == 16'h0)) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_wait_d = n_wait_q;
    hit_d    = hit_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_d     = '0;
    wr_d     = '0;
    ioreq_d  = cond;
    case (state_q)
      S_IDLE: begin
        if (cond && !ioreq_q) begin
          addr_d  = a;
          hit_d   = win;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (|(hit_q & port_wait)) begin
          cnt_d    = 4'(WAIT_CYCLES);
          n_wait_d = 1'b0;
          state_d  = S_WAIT;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d    = 4'd0;
          n_wait_d = 1'b1;
          state_d  = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        if (rd_s) begin
          rd_d    = hit_q;
          state_d = S_DONE;
        end else if (wr_s) begin
          wr_d    = hit_q;
          if (|hit_q) data_d = d;
          state_d = S_DONE;
        end
      end
      default: ;
    endcase
    // Losing iorq aborts any cycle in flight, dropping a pending strobe.
    if (state_q != S_IDLE && !iorq_s) begin
      state_d  = S_IDLE;
      hit_d    = '0;
      n_wait_d = 1'b1;
      cnt_d    = 4'd0;
      rd_d     = '0;
      wr_d     = '0;
      data_d   = data_q;
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      sync_q   <= '1;
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      ioreq_q  <= 1'b0;
      n_wait_q <= 1'b1;
      hit_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      addr_q   <= 16'h0;
      data_q   <= 8'h0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ioreq_q  <= ioreq_d;
      n_wait_q <= n_wait_d;
      hit_q    <= hit_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign ioreq    = ioreq_q;
  assign hit      = hit_q;
  assign rd_stb   = rd_q;
  assign wr_stb   = wr_q;
  assign addr_lat = addr_q;
  assign data_lat = data_q;
  assign n_wait   = n_wait_q;

endmodule

// File: doc/cpu_io_decoder.md
# cpu_io_decoder

Parametrised Z80 I/O cycle decoder for the CPLD. It samples the asynchronous CPU bus into the `clk28` domain and tracks each I/O cycle with a small state machine. For PORTS decode channels it produces single-cycle read/write strobes, a latched address/data snapshot and an optional per-channel wait-state request. It sits between the CPU pins and the peripheral register blocks, and replaces per-peripheral ad-hoc port decoding.

## Interface
Parameters:
- PORTS, 4: number of decode channels, 1..16.
- SYNC_STAGES, 2: synchronizer depth for control strobes, 2..3.
- PORT_ADDR, 0: PORTS×16 packed match addresses; channel i occupies bits [16i+15:16i].
- PORT_MASK, 0: PORTS×16 packed masks; a 1 bit means "compare this bit".
- WAIT_CYCLES, 4: `clk28` cycles of wait request for channels with wait enabled, 1..15.

Ports:
- clk28  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- a  in  16  CPU address bus.
- d  in  8  CPU data bus.
- n_iorq, n_m1, n_rd, n_wr  in  1 each  CPU strobes, active-low, asynchronous.
- port_en  in  PORTS  runtime enable per channel; a disabled channel never hits.
- port_wait  in  PORTS  channel requests wait states.
- ioreq  out  1  synchronized I/O cycle in progress, interrupt acknowledge excluded.
- hit  out  PORTS  one-hot winning channel, held for the cycle.
- rd_stb  out  PORTS  one-clock read strobe.
- wr_stb  out  PORTS  one-clock write strobe.
- addr_lat  out  16  address latched at cycle start.
- data_lat  out  8  write data latched with wr_stb.
- n_wait  out  1  active-low wait request to the CPU.

## Operation
- Synchronize n_iorq, n_m1, n_rd and n_wr through SYNC_STAGES flops each. `a` and `d` are sampled unsynchronized only at the defined latch points.
- I/O cycle condition is `iorq_s & ~m1_s`, using active-high synchronized versions. When iorq and m1 are both asserted (INTA), the cycle is ignored: no hit, no strobes, ioreq=0.
- Match for channel i: `((a ^ PORT_ADDR[i]) & PORT_MASK[i]) == 0 && port_en[i]`. If several channels match, the lowest index wins, so hit is strictly one-hot or zero.
- FSM states:
  - IDLE: when the cycle condition rises, latch `a` into addr_lat, compute hit, go to DECODE.
  - DECODE: if the winner has port_wait set, load the counter with WAIT_CYCLES, assert n_wait=0, go to WAIT. Otherwise go to ACCESS.
  - WAIT: decrement the counter. At 0, release n_wait=1 and go to ACCESS.
  - ACCESS: on the first cycle where rd_s=1, pulse rd_stb[winner]. On the first cycle where wr_s=1, latch `d` into data_lat and pulse wr_stb[winner]. Only one of these fires per cycle, whichever is seen first. Then go to DONE.
  - DONE: hold hit. When iorq_s=0, clear hit and go to IDLE.
- Negation of iorq_s in any non-IDLE state returns the FSM to IDLE next clock, clears hit and forces n_wait=1. A strobe not yet emitted is dropped.
- With no winner, the FSM still tracks the cycle and ioreq, but emits no strobes and no wait.

## Timing
- Reset values: ioreq=0, hit=0, rd_stb=0, wr_stb=0, addr_lat=0, data_lat=0, n_wait=1, FSM=IDLE, counter=0.
- Latency from a pin edge to the synchronized signal is SYNC_STAGES clocks.
- addr_lat and hit are valid 1 clock after iorq_s rises. ioreq rises on the same clock.
- Without wait: the strobe comes ≥2 clocks after iorq_s rises, and 1 clock after rd_s/wr_s is seen in ACCESS.
- With wait: n_wait is low for exactly WAIT_CYCLES clocks, starting the clock after DECODE. The strobe comes no earlier than 1 clock after n_wait releases.
- data_lat updates on the same edge that asserts wr_stb and holds until the next write.
- Each strobe is exactly 1 clock wide, with at most one per I/O cycle.
- rst asserted at any time forces all outputs to their reset values immediately, including n_wait=1.

## Test plan
- Channel 0: PORT_ADDR=0x00FE, PORT_MASK=0x00FF. OUT (0x12FE),0x5A -> hit[0]=1, one wr_stb[0] pulse, data_lat=0x5A, addr_lat=0x12FE, no rd_stb.
- Channels 0 and 1 both match 0x7FFD. IN from 0x7FFD -> hit=0b01, a single rd_stb[0], rd_stb[1] never asserts.
- port_wait[2]=1, WAIT_CYCLES=4. Access channel 2 -> n_wait low for exactly 4 clocks, then one strobe. Other channels -> n_wait stays 1.
- INTA cycle (n_iorq=0, n_m1=0) with an address matching channel 0 -> ioreq=0, hit=0, no strobes.
- port_en[0]=0 and the address matches channel 0 -> no hit, no strobe. Set port_en[0]=1 and repeat -> one strobe.
- Assert rst mid-WAIT -> n_wait=1 and hit=0 immediately. After release, the next cycle decodes normally.
